// File: rtl/lpa_pkg.sv
// Shared definitions for local_port_arbiter: FSM state encoding and
// index-width helper used to size requester indices.
package lpa_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        RELEASE  = 2'b10
    } lpa_state_e;

    // ceil(log2(n)), never less than 1 so a 2-requester index still has a bit
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1 with wrap-around, so the previous winner has lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    int idx;

    // Scan offsets 1..NUM_REQ from the last winner; the first hit wins
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any && (j == idx) && req[j]) begin
                    winner = IDX_W'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/local_port_arbiter.sv
// Round-robin arbiter sharing one router local input port among numReq
// packet sources. The winning packet is latched and offered downstream with
// a Req/Gnt handshake; the router's grant is returned to the winner as a
// one-cycle pulse. Optional downstream-grant timeout: define LPA_TIMEOUT_EN.
module local_port_arbiter
    import lpa_pkg::*;
#(
    parameter int numReq        = 4,
    parameter int dataWidth     = 32,
    parameter int timeoutCycles = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [numReq-1:0]           ReqIn,
    input  logic [numReq*dataWidth-1:0] PacketIn,
    output logic [numReq-1:0]           GntOut,
    output logic [dataWidth-1:0]        PacketOut,
    output logic                        ReqDnStr,
    input  logic                        GntDnStr,
    input  logic                        DnStrFull,
    output logic                        TimeoutErr
);

    localparam int IDX_W = idx_width(numReq);

    if (numReq < 2 || numReq > 16 || timeoutCycles < 1 || timeoutCycles > 65535) begin : g_param_check
        $error("local_port_arbiter: parameter out of range");
    end

    lpa_state_e             state_q, state_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic [IDX_W-1:0]       lastGnt_q, lastGnt_d;
    logic [dataWidth-1:0]   pkt_q, pkt_d;
    logic                   reqdn_q, reqdn_d;
    logic [numReq-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]       pick_w;
    logic                   pick_any;

`ifdef LPA_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(timeoutCycles - 1);
    logic [15:0]            cnt_q, cnt_d;
    logic                   terr_q, terr_d;
`endif

    rr_pick #(
        .NUM_REQ (numReq),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (ReqIn),
        .last   (lastGnt_q),
        .winner (pick_w),
        .any    (pick_any)
    );

    // Arbitration FSM next-state and registered-output next values
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        lastGnt_d = lastGnt_q;
        pkt_d     = pkt_q;
        reqdn_d   = reqdn_q;
        gnt_d     = '0;
`ifdef LPA_TIMEOUT_EN
        cnt_d     = cnt_q;
        terr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any && !DnStrFull) begin
                    winner_d = pick_w;
                    for (int i = 0; i < numReq; i++) begin
                        if (pick_w == IDX_W'(i)) begin
                            pkt_d = PacketIn[i*dataWidth +: dataWidth];
                        end
                    end
                    reqdn_d = 1'b1;
                    state_d = WAIT_GNT;
`ifdef LPA_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_GNT: begin
                if (GntDnStr) begin
                    reqdn_d   = 1'b0;
                    lastGnt_d = winner_q;
                    for (int i = 0; i < numReq; i++) begin
                        gnt_d[i] = (winner_q == IDX_W'(i));
                    end
                    state_d   = RELEASE;
                end
`ifdef LPA_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // Give up on this packet; rotate priority past the stalled winner
                    reqdn_d   = 1'b0;
                    terr_d    = 1'b1;
                    lastGnt_d = winner_q;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                reqdn_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            lastGnt_q <= IDX_W'(numReq - 1);
            pkt_q     <= '0;
            reqdn_q   <= 1'b0;
            gnt_q     <= '0;
`ifdef LPA_TIMEOUT_EN
            cnt_q     <= '0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            lastGnt_q <= lastGnt_d;
            pkt_q     <= pkt_d;
            reqdn_q   <= reqdn_d;
            gnt_q     <= gnt_d;
`ifdef LPA_TIMEOUT_EN
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign GntOut    = gnt_q;
    assign PacketOut = pkt_q;
    assign ReqDnStr  = reqdn_q;
`ifdef LPA_TIMEOUT_EN
    assign TimeoutErr = terr_q;
`else
    assign TimeoutErr = 1'b0;
`endif

endmodule
